// File: rtl/share_encoder_d3.sv
// share_encoder_d3: splits two operand bits into 4-share Boolean maskings
// and supplies fresh ISW randomness from a reseedable 64-bit LFSR.
// Ports: clk, reset (async, active-low), seed/seed_valid (LFSR load),
// in_a/in_b/in_valid -> in_ready (operand handshake), port_a_*/port_b_*
// (shares), port_r_* (ISW randomness), share_valid, c_valid (product flag).
module share_encoder_d3 #(
    parameter int LAT    = 3,
    parameter int WARMUP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] seed,
    input  logic        seed_valid,
    input  logic        in_a,
    input  logic        in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        port_a_0,
    output logic        port_a_1,
    output logic        port_a_2,
    output logic        port_a_3,
    output logic        port_b_0,
    output logic        port_b_1,
    output logic        port_b_2,
    output logic        port_b_3,
    output logic        port_r_0,
    output logic        port_r_1,
    output logic        port_r_2,
    output logic        port_r_3,
    output logic        port_r_4,
    output logic        port_r_5,
    output logic        share_valid,
    output logic        c_valid
);

    localparam int CW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

    typedef enum logic [1:0] {UNSEEDED, WARM, RUN} state_t;

    state_t         state;
    logic [63:0]    lfsr;
    logic [63:0]    lfsr_nxt;
    logic [CW-1:0]  cnt;
    logic [LAT-1:0] c_pipe;
    logic [3:0]     a_q;
    logic [3:0]     b_q;
    logic [5:0]     r_q;
    logic [11:0]    f;
    logic           accept;
    logic           active;

    // Twelve Fibonacci steps, x^64+x^63+x^61+x^60+1.
    function automatic logic [63:0] step12(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < 12; i++)
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        return t;
    endfunction

    assign lfsr_nxt = step12(lfsr);
    assign f        = lfsr_nxt[11:0];
    assign active   = (state != UNSEEDED);
    assign in_ready = (state == RUN) && !seed_valid;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= UNSEEDED;
            lfsr        <= '0;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            share_valid <= 1'b0;
            c_pipe      <= '0;
        end else begin
            // Keeps shifting across reseeds so in-flight products still flag.
            c_pipe      <= (c_pipe << 1) | LAT'(share_valid);
            share_valid <= accept;
            // Plain operand bit only ever leaves masked, in share 3.
            a_q <= accept ? {in_a ^ f[0] ^ f[1] ^ f[2], f[2:0]} : 4'b0;
            b_q <= accept ? {in_b ^ f[3] ^ f[4] ^ f[5], f[5:3]} : 4'b0;
            r_q <= active ? f[11:6] : 6'b0;
            if (seed_valid) begin
                lfsr  <= (seed == 64'h0) ? 64'h1 : seed;
                cnt   <= CW'(WARMUP);
                state <= WARM;
            end else begin
                case (state)
                    UNSEEDED: ;
                    WARM: begin
                        lfsr <= lfsr_nxt;
                        if (cnt <= CW'(1)) begin
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    RUN:     lfsr  <= lfsr_nxt;
                    default: state <= UNSEEDED;
                endcase
            end
        end
    end

    assign c_valid  = c_pipe[LAT-1];
    assign port_a_0 = a_q[0];
    assign port_a_1 = a_q[1];
    assign port_a_2 = a_q[2];
    assign port_a_3 = a_q[3];
    assign port_b_0 = b_q[0];
    assign port_b_1 = b_q[1];
    assign port_b_2 = b_q[2];
    assign port_b_3 = b_q[3];
    assign port_r_0 = r_q[0];
    assign port_r_1 = r_q[1];
    assign port_r_2 = r_q[2];
    assign port_r_3 = r_q[3];
    assign port_r_4 = r_q[4];
    assign port_r_5 = r_q[5];

endmodule

// File: tb/tb_share_encoder_d3.sv
// tb_share_encoder_d3: randomized bench for share_encoder_d3 against a
// bit-stream reference model of the LFSR, the FSM and the c_valid delay.
module tb_share_encoder_d3;

    localparam int LAT    = 3;
    localparam int WARMUP = 4;
    localparam int M_U = 0;
    localparam int M_W = 1;
    localparam int M_R = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] seed = '0;
    logic        seed_valid = 1'b0;
    logic        in_a = 1'b0;
    logic        in_b = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        port_a_0, port_a_1, port_a_2, port_a_3;
    logic        port_b_0, port_b_1, port_b_2, port_b_3;
    logic        port_r_0, port_r_1, port_r_2, port_r_3, port_r_4, port_r_5;
    logic        share_valid;
    logic        c_valid;

    share_encoder_d3 #(.LAT(LAT), .WARMUP(WARMUP)) dut (
        .clk(clk), .reset(reset), .seed(seed), .seed_valid(seed_valid),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
        .port_a_0(port_a_0), .port_a_1(port_a_1),
        .port_a_2(port_a_2), .port_a_3(port_a_3),
        .port_b_0(port_b_0), .port_b_1(port_b_1),
        .port_b_2(port_b_2), .port_b_3(port_b_3),
        .port_r_0(port_r_0), .port_r_1(port_r_1), .port_r_2(port_r_2),
        .port_r_3(port_r_3), .port_r_4(port_r_4), .port_r_5(port_r_5),
        .share_valid(share_valid), .c_valid(c_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;

    // Reference model: LFSR as a bit stream, oldest bit at index 0.
    bit         mq[$];
    int         m_state;
    int         m_left;
    logic [3:0] e_a, e_b;
    logic [5:0] e_r;
    logic       e_sv, e_ia, e_ib;
    bit         sv_hist[$];
    logic       rdy_seen;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_load(input logic [63:0] s);
        mq.delete();
        for (int i = 63; i >= 0; i--) mq.push_back(s[i]);
    endfunction

    // New bit = x[n-64]^x[n-63]^x[n-61]^x[n-60] over the stream.
    function automatic logic [11:0] m_fresh(input bit adv);
        bit t[$];
        logic [11:0] fv;
        t = mq;
        for (int k = 0; k < 12; k++) begin
            t.push_back(t[0] ^ t[1] ^ t[3] ^ t[4]);
            void'(t.pop_front());
        end
        for (int j = 0; j < 12; j++) fv[j] = t[63-j];
        if (adv) mq = t;
        return fv;
    endfunction

    function automatic void m_reset();
        m_state = M_U;
        m_left  = 0;
        m_load(64'h0);
        e_a = '0; e_b = '0; e_r = '0; e_sv = 1'b0;
        e_ia = 1'b0; e_ib = 1'b0;
        sv_hist.delete();
    endfunction

    task automatic tick();
        logic [11:0] fv;
        logic rdy, acc, e_cv;
        @(negedge clk);
        rdy = (m_state == M_R) && !seed_valid;
        rdy_seen = in_ready;
        chk("in_ready", in_ready, rdy);
        fv  = m_fresh(1'b0);
        acc = in_valid && rdy;
        e_a = acc ? {in_a ^ fv[0] ^ fv[1] ^ fv[2], fv[2:0]} : 4'b0;
        e_b = acc ? {in_b ^ fv[3] ^ fv[4] ^ fv[5], fv[5:3]} : 4'b0;
        e_r = (m_state != M_U) ? fv[11:6] : 6'b0;
        e_sv = acc;
        if (acc) begin
            e_ia = in_a;
            e_ib = in_b;
            n_acc++;
        end
        if (seed_valid) begin
            m_load((seed == 64'h0) ? 64'h1 : seed);
            m_state = M_W;
            m_left  = WARMUP;
        end else if (m_state == M_W) begin
            void'(m_fresh(1'b1));
            if (m_left <= 1) m_state = M_R;
            else m_left--;
        end else if (m_state == M_R) begin
            void'(m_fresh(1'b1));
        end
        sv_hist.push_back(acc);
        e_cv = (sv_hist.size() > LAT) ? sv_hist[sv_hist.size()-1-LAT] : 1'b0;
        if (sv_hist.size() > LAT + 1) void'(sv_hist.pop_front());
        @(posedge clk);
        #1;
        chk("share_valid", share_valid, e_sv);
        chk("port_a", {port_a_3, port_a_2, port_a_1, port_a_0}, e_a);
        chk("port_b", {port_b_3, port_b_2, port_b_1, port_b_0}, e_b);
        chk("port_r", {port_r_5, port_r_4, port_r_3, port_r_2,
                       port_r_1, port_r_0}, e_r);
        chk("c_valid", c_valid, e_cv);
        if (e_sv) begin
            chk("xor_a", port_a_0 ^ port_a_1 ^ port_a_2 ^ port_a_3, e_ia);
            chk("xor_b", port_b_0 ^ port_b_1 ^ port_b_2 ^ port_b_3, e_ib);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_sv", share_valid, 0);
        chk("rst_cv", c_valid, 0);
        chk("rst_a", {port_a_3, port_a_2, port_a_1, port_a_0}, 0);
        chk("rst_b", {port_b_3, port_b_2, port_b_1, port_b_0}, 0);
        chk("rst_r", {port_r_5, port_r_4, port_r_3, port_r_2,
                      port_r_1, port_r_0}, 0);
        chk("rst_rdy", in_ready, 0);
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic reach_run(input logic [63:0] s);
        seed = s;
        seed_valid = 1'b1;
        in_valid = 1'b0;
        tick();
        seed_valid = 1'b0;
        for (int k = 0; k < WARMUP; k++) tick();
    endtask

    initial begin
        int k;
        int cyc;
        logic seen;
        m_reset();
        @(posedge clk);
        #1;
        do_reset();

        // No seed: never ready, no shares, no randomness.
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_a = 1'($urandom_range(0, 1));
            in_b = 1'($urandom_range(0, 1));
            tick();
        end

        // Seed at t0 with in_valid held: ready at t0+1+WARMUP.
        seed = 64'h1;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        k = 0;
        rdy_seen = 1'b0;
        while (!rdy_seen && k < 50) begin
            tick();
            k++;
        end
        chk("ready_rise", k, WARMUP + 1);
        chk("first_sv", share_valid, 1);

        // 1000 random accepts with occasional idle cycles.
        n_acc = 0;
        cyc = 0;
        while (n_acc < 1000 && cyc < 4000) begin
            in_valid = ($urandom_range(0, 4) != 0);
            in_a = 1'($urandom_range(0, 1));
            in_b = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        chk("accepts", n_acc, 1000);

        // Zero seed behaves as seed 1; same seed twice repeats.
        in_valid = 1'b1;
        reach_run(64'h0);
        for (int i = 0; i < 30; i++) tick();
        reach_run(64'h1);
        for (int i = 0; i < 30; i++) tick();
        seed = {$urandom, $urandom};
        reach_run(seed);
        for (int i = 0; i < 20; i++) tick();
        reach_run(seed);
        for (int i = 0; i < 20; i++) tick();

        // Reseed collides with in_valid; earlier product still flags.
        in_valid = 1'b1;
        in_a = 1'b1;
        tick();
        chk("pre_seed_sv", share_valid, 1);
        seed = {$urandom, $urandom};
        seed_valid = 1'b1;
        tick();
        chk("seed_win_sv", share_valid, 0);
        seed_valid = 1'b0;
        for (int i = 0; i < LAT - 1; i++) tick();
        chk("cv_thru_seed", c_valid, 1);
        for (int i = 0; i < WARMUP; i++) tick();

        // Reset while share_valid is high drops the in-flight flag.
        in_valid = 1'b1;
        tick();
        chk("pre_rst_sv", share_valid, 1);
        do_reset();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            seen = seen | c_valid;
        end
        chk("cv_after_rst", seen, 0);

        // Mixed random traffic with sporadic reseeds.
        reach_run({$urandom, $urandom});
        for (int i = 0; i < 400; i++) begin
            seed_valid = ($urandom_range(0, 39) == 0);
            seed = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = 1'($urandom_range(0, 1));
            in_b = 1'($urandom_range(0, 1));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
